// File: rtl/rob_id_alloc.sv
// rob_id_alloc: dispatch-side ROB slot ID allocator.
//
// Hands out up to two ROB IDs per cycle in program order, tracks head,
// tail and occupancy, frees up to four slots per cycle on retire, and
// stops granting once an end-of-program instruction has been allocated
// (HALT) until a flush.
//
// Handshake: grant1/grant2 are combinational acknowledgements of
// req1_valid/req2_valid for the current cycle; an ID is consumed exactly
// when its grant is high, and the requester must hold its request until
// granted. Slot 2 is only ever granted together with slot 1.
//
// Optional feature macro: ROB_ALLOC_CHECK_EN
//   defined   : retire underflow clamps occupancy at 0, sets sticky err and
//               reports an $error.
//   undefined : occupancy wraps on underflow and err is tied low.

module rob_id_alloc #(
  parameter int ID_W  = 5,
  parameter int DEPTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req1_valid,
  input  logic            req1_end,
  input  logic            req2_valid,
  input  logic            req2_end,
  input  logic [2:0]      retire_cnt,
  input  logic            flush,
  output logic            grant1,
  output logic            grant2,
  output logic [ID_W-1:0] id1,
  output logic [ID_W-1:0] id2,
  output logic [ID_W-1:0] head,
  output logic [ID_W:0]   occupancy,
  output logic            full,
  output logic            empty,
  output logic            halted,
  output logic            err
);

  // Occupancy-width constants used by the free-space checks.
  localparam logic [ID_W:0] DEPTH_W  = DEPTH[ID_W:0];
  localparam logic [ID_W:0] FREE_ONE = (ID_W+1)'(1);
  localparam logic [ID_W:0] FREE_TWO = (ID_W+1)'(2);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] tail_q;
  logic [ID_W-1:0] head_q;
  logic [ID_W:0]   occ_q;

  logic [ID_W-1:0] tail_d;
  logic [ID_W-1:0] head_d;
  logic [ID_W:0]   occ_d;
  logic [ID_W:0]   free_slots;
  logic [ID_W:0]   alloc_cnt;
  logic [ID_W:0]   retire_ext;
  logic [ID_W:0]   retire_eff;
  logic            can_alloc;
  logic            end_granted;

`ifdef ROB_ALLOC_CHECK_EN
  logic            underflow;
  logic            err_q;
`endif

  // Free space comes from registered occupancy only, so a retire in the
  // same cycle never opens room for a grant until the next cycle.
  always_comb begin
    free_slots = DEPTH_W - occ_q;
    can_alloc  = (state_q == ST_RUN) && !flush && !reset;
    grant1     = can_alloc && req1_valid && (free_slots >= FREE_ONE);
    grant2     = can_alloc && req1_valid && req2_valid && !req1_end &&
                 (free_slots >= FREE_TWO);
  end

  // IDs are always presented; they only mean something when granted.
  assign id1 = tail_q;
  assign id2 = tail_q + ID_W'(1);

  // Retire amount actually applied; with checking on, never free more
  // slots than are in flight.
  always_comb begin
    retire_ext = (ID_W+1)'(retire_cnt);
`ifdef ROB_ALLOC_CHECK_EN
    underflow  = (retire_ext > occ_q);
    retire_eff = underflow ? occ_q : retire_ext;
`else
    retire_eff = retire_ext;
`endif
  end

  // Next values of the pointers and occupancy for a non-flush cycle.
  always_comb begin
    alloc_cnt   = (ID_W+1)'(grant1) + (ID_W+1)'(grant2);
    tail_d      = tail_q + ID_W'(grant1) + ID_W'(grant2);
    head_d      = head_q + retire_eff[ID_W-1:0];
    occ_d       = occ_q + alloc_cnt - retire_eff;
    end_granted = (grant1 && req1_end) || (grant2 && req2_end);
  end

  // FSM next state: halt once an end marker is handed an ID, resume only
  // on flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_RUN;
        end else if (end_granted) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (flush) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer and occupancy registers; flush discards everything in flight
  // and wins over same-cycle grants and retires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tail_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      tail_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
    end else begin
      tail_q <= tail_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

`ifdef ROB_ALLOC_CHECK_EN
  // Sticky underflow flag; survives flush, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!flush && underflow) begin
      err_q <= 1'b1;
      $error("rob_id_alloc: retire underflow at %0t: retire_cnt=%0d occ=%0d",
             $time, retire_cnt, occ_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Status outputs derived straight from registered state.
  assign head      = head_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == DEPTH_W);
  assign empty     = (occ_q == '0);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_rob_id_alloc.sv
// tb_rob_id_alloc: table-driven bench for rob_id_alloc with an expected
// queue; rows carry inputs plus the outputs expected in that same cycle
// (state shown is the registered state before that cycle's update).

module tb_rob_id_alloc;

  localparam int ID_W  = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic       r1v;
    logic       r1e;
    logic       r2v;
    logic       r2e;
    logic [2:0] ret;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic [4:0] id1;
    logic [4:0] id2;
    logic [4:0] head;
    logic [5:0] occ;
    logic       full;
    logic       empty;
    logic       halted;
    logic       err;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
    string name;
  } vec_t;

  localparam int EW = $bits(exp_t);

  logic            clock;
  logic            reset;
  logic            req1_valid;
  logic            req1_end;
  logic            req2_valid;
  logic            req2_end;
  logic [2:0]      retire_cnt;
  logic            flush;
  logic            grant1;
  logic            grant2;
  logic [ID_W-1:0] id1;
  logic [ID_W-1:0] id2;
  logic [ID_W-1:0] head;
  logic [ID_W:0]   occupancy;
  logic            full;
  logic            empty;
  logic            halted;
  logic            err;

  logic [EW-1:0] exp_q[$];
  vec_t          tbl[$];
  int            n_vec  = 0;
  int            n_miss = 0;

  // Reference model state used for the random phase.
  int m_tail;
  int m_head;
  int m_occ;
  bit m_halt;

  rob_id_alloc #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req1_valid (req1_valid),
    .req1_end   (req1_end),
    .req2_valid (req2_valid),
    .req2_end   (req2_end),
    .retire_cnt (retire_cnt),
    .flush      (flush),
    .grant1     (grant1),
    .grant2     (grant2),
    .id1        (id1),
    .id2        (id2),
    .head       (head),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .halted     (halted),
    .err        (err)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Row builders.
  function automatic stim_t mk_s(logic r1v, logic r1e, logic r2v, logic r2e,
                                 int ret, logic fl);
    stim_t s;
    s.r1v = r1v; s.r1e = r1e; s.r2v = r2v; s.r2e = r2e;
    s.ret = 3'(ret); s.fl = fl;
    return s;
  endfunction

  function automatic exp_t mk_e(logic g1, logic g2, int id_1, int hd, int oc,
                                logic hl, logic er);
    exp_t e;
    e.g1 = g1; e.g2 = g2;
    e.id1 = 5'(id_1); e.id2 = 5'((id_1 + 1) % DEPTH);
    e.head = 5'(hd); e.occ = 6'(oc);
    e.full = (oc == DEPTH); e.empty = (oc == 0);
    e.halted = hl; e.err = er;
    return e;
  endfunction

  function automatic void add(string name, stim_t s, exp_t e);
    vec_t v;
    v.s = s; v.e = e; v.name = name;
    tbl.push_back(v);
  endfunction

  // Spec-level model: expected outputs for one cycle, then advance.
  function automatic void model_step(string name, stim_t s);
    int  free_n;
    bit  g1;
    bit  g2;
    free_n = DEPTH - m_occ;
    g1 = !m_halt && !s.fl && s.r1v && (free_n >= 1);
    g2 = !m_halt && !s.fl && s.r1v && s.r2v && !s.r1e && (free_n >= 2);
    add(name, s, mk_e(g1, g2, m_tail, m_head, m_occ, m_halt, 1'b0));
    if (s.fl) begin
      m_tail = 0; m_head = 0; m_occ = 0; m_halt = 1'b0;
    end else begin
      m_tail = (m_tail + int'(g1) + int'(g2)) % DEPTH;
      m_head = (m_head + int'(s.ret)) % DEPTH;
      m_occ  = m_occ + int'(g1) + int'(g2) - int'(s.ret);
      if ((g1 && s.r1e) || (g2 && s.r2e)) m_halt = 1'b1;
    end
  endfunction

  // Driver.
  task automatic drive(stim_t s);
    req1_valid = s.r1v;
    req1_end   = s.r1e;
    req2_valid = s.r2v;
    req2_end   = s.r2e;
    retire_cnt = s.ret;
    flush      = s.fl;
  endtask

  // Scoreboard compare against the head of the expected queue.
  task automatic check_out(string name);
    exp_t a;
    exp_t e;
    a = {grant1, grant2, id1, id2, head, occupancy, full, empty, halted, err};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got g=%b%b id=%0d/%0d head=%0d occ=%0d full=%b empty=%b halted=%b err=%b, required g=%b%b id=%0d/%0d head=%0d occ=%0d full=%b empty=%b halted=%b err=%b",
                 name, a.g1, a.g2, a.id1, a.id2, a.head, a.occ, a.full, a.empty, a.halted, a.err,
                 e.g1, e.g2, e.id1, e.id2, e.head, e.occ, e.full, e.empty, e.halted, e.err);
      end
    end
  endtask

  // One row: drive at posedge+1, compare at negedge, return at posedge+1.
  task automatic run_vec(vec_t v);
    drive(v.s);
    exp_q.push_back(v.e);
    @(negedge clock);
    check_out(v.name);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    tbl.delete();
  endtask

  stim_t dual;
  stim_t idle;

  initial begin
    dual  = mk_s(1, 0, 1, 0, 0, 0);
    idle  = mk_s(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(dual);

    // Reset state: no grants even with requests pending.
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    check_out("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill with dual grants, then full, then full plus retire.
    for (int i = 0; i < 16; i++)
      add($sformatf("fill_%0d", i), dual, mk_e(1, 1, 2*i, 0, 2*i, 0, 0));
    add("full_no_grant", dual, mk_e(0, 0, 0, 0, 32, 0, 0));
    add("full_retire1", mk_s(1, 0, 1, 0, 1, 0), mk_e(0, 0, 0, 0, 32, 0, 0));
    add("after_retire", dual, mk_e(1, 0, 0, 1, 31, 0, 0));
    // Flush beats same-cycle requests and retires.
    add("flush_dual_ret2", mk_s(1, 0, 1, 0, 2, 1), mk_e(0, 0, 1, 1, 32, 0, 0));
    add("post_flush_req1", mk_s(1, 0, 0, 0, 0, 0), mk_e(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++)
      add($sformatf("refill_%0d", i), dual, mk_e(1, 1, 1+2*i, 0, 1+2*i, 0, 0));
    // Occupancy 31 at tail 31 with a retire of 4.
    add("occ31_tail31_ret4", mk_s(1, 0, 1, 0, 4, 0), mk_e(1, 0, 31, 0, 31, 0, 0));
    add("wrap_dual", dual, mk_e(1, 1, 0, 4, 28, 0, 0));
    // End marker in slot 1.
    add("end_slot1", mk_s(1, 1, 1, 0, 0, 0), mk_e(1, 0, 2, 4, 30, 0, 0));
    add("halted_no_grant", dual, mk_e(0, 0, 3, 4, 31, 1, 0));
    for (int k = 0; k < 7; k++)
      add($sformatf("drain_%0d", k), mk_s(1, 0, 0, 0, 4, 0),
          mk_e(0, 0, 3, (4+4*k) % 32, 31-4*k, 1, 0));
    add("drain_last", mk_s(1, 0, 0, 0, 3, 0), mk_e(0, 0, 3, 0, 3, 1, 0));
    add("halted_empty", dual, mk_e(0, 0, 3, 3, 0, 1, 0));
    add("flush_halt", dual, mk_s(1, 0, 1, 0, 0, 1) == dual ? mk_e(0, 0, 0, 0, 0, 0, 0)
                                                           : mk_e(0, 0, 3, 3, 0, 1, 0));
    tbl[tbl.size()-1].s = mk_s(1, 0, 1, 0, 0, 1);
    add("run_after_flush", dual, mk_e(1, 1, 0, 0, 0, 0, 0));
    apply_tbl();

    // End marker in slot 2 and a lone slot-2 request.
    add("end_slot2", mk_s(1, 0, 1, 1, 0, 0), mk_e(1, 1, 2, 0, 2, 0, 0));
    add("halted_slot2", dual, mk_e(0, 0, 4, 0, 4, 1, 0));
    add("flush_idle", mk_s(0, 0, 0, 0, 0, 1), mk_e(0, 0, 4, 0, 4, 1, 0));
    add("req2_alone", mk_s(0, 0, 1, 0, 0, 0), mk_e(0, 0, 0, 0, 0, 0, 0));
    add("pre_async_reset", dual, mk_e(1, 1, 0, 0, 0, 0, 0));
    apply_tbl();

    // Asynchronous reset mid-cycle clears state before the next edge.
    drive(dual);
    #2;
    reset = 1'b1;
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    #1;
    check_out("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    add("first_after_reset", dual, mk_e(1, 1, 0, 0, 0, 0, 0));
    apply_tbl();

    // Random traffic against the model.
    m_tail = 2; m_head = 0; m_occ = 2; m_halt = 1'b0;
    for (int i = 0; i < 80; i++) begin
      stim_t s;
      int    hi;
      hi    = (m_occ < 4) ? m_occ : 4;
      s.r1v = ($urandom_range(0, 3) != 0);
      s.r1e = ($urandom_range(0, 19) == 0);
      s.r2v = ($urandom_range(0, 1) != 0);
      s.r2e = ($urandom_range(0, 19) == 0);
      s.ret = 3'($urandom_range(0, hi));
      s.fl  = m_halt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      model_step($sformatf("rand_%0d", i), s);
    end
    model_step("rand_flush", mk_s(0, 0, 0, 0, 0, 1));
    apply_tbl();

`ifdef ROB_ALLOC_CHECK_EN
    // Underflow clamps occupancy, sets sticky err, survives flush.
    add("uf_alloc", mk_s(1, 0, 0, 0, 0, 0), mk_e(1, 0, 0, 0, 0, 0, 0));
    add("uf_retire3", mk_s(0, 0, 0, 0, 3, 0), mk_e(0, 0, 1, 0, 1, 0, 0));
    add("uf_sticky", idle, mk_e(0, 0, 1, 1, 0, 0, 1));
    add("uf_flush", mk_s(0, 0, 0, 0, 0, 1), mk_e(0, 0, 1, 1, 0, 0, 1));
    add("uf_after_flush", idle, mk_e(0, 0, 0, 0, 0, 0, 1));
    apply_tbl();
    drive(idle);
    #2;
    reset = 1'b1;
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    #1;
    check_out("uf_reset_clears_err");
    @(posedge clock);
    #1;
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
